// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if: control, event and readout signals of one performance counter bank.
// Latency: none (wires only); the master drives stimulus, the slave returns rd_data and overflow.
// Backpressure: none; every signal is sampled or presented every cycle.
interface perf_counter_bank_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                enable;
    logic [CHANNELS-1:0] evt;
    logic [CHANNELS-1:0] clear;
    logic                snap;
    logic [SEL_W-1:0]    rd_sel;
    logic [WIDTH-1:0]    rd_data;
    logic [CHANNELS-1:0] overflow;

    modport master (
        output enable, evt, clear, snap, rd_sel,
        input  rd_data, overflow
    );

    modport slave (
        input  enable, evt, clear, snap, rd_sel,
        output rd_data, overflow
    );
endinterface

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: per-channel qualified event counters with sticky overflow, snapshot option PERF_COUNTER_SNAPSHOT_EN.
// Latency: a count moves at the edge ending the QUAL-th high cycle; rd_data shows the pre-edge source one edge later.
// Backpressure: none; event, clear and snap are sampled every cycle and never stalled.
module perf_counter_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int QUAL     = 3,
    parameter int SATURATE = 0
) (
    input logic                clk,
    input logic                reset,
    perf_counter_bank_if.slave bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int QW    = $clog2(QUAL + 1);
    localparam logic [QW-1:0] QUAL_DONE = QW'(QUAL);
    localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL - 1);

    logic [CHANNELS-1:0] live;
    logic [CHANNELS-1:0] hit;
    logic [QW-1:0]       qual_cnt [CHANNELS];
    logic [WIDTH-1:0]    count    [CHANNELS];
    logic [CHANNELS-1:0] ovf;
    logic [WIDTH-1:0]    src      [CHANNELS];
    logic [WIDTH-1:0]    sel_val;

    // Global enable masks every event input before qualification.
    assign live = bus.evt & {CHANNELS{bus.enable}};

    // A channel qualifies in the cycle its run reaches QUAL; a same-cycle clear suppresses the increment.
    always_comb begin
        hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i] = live[i] && !bus.clear[i] && (qual_cnt[i] == QUAL_LAST);
        end
    end

    // Qualifier: counts consecutive high cycles, parks at QUAL until the input drops; clear restarts it
    // so a high input during clear only starts a new run on the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                qual_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.clear[i] || !live[i]) begin
                    qual_cnt[i] <= '0;
                end else if (qual_cnt[i] != QUAL_DONE) begin
                    qual_cnt[i] <= qual_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Counters with sticky overflow: an increment at all-ones wraps or holds, and always flags overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.clear[i]) begin
                    count[i] <= '0;
                    ovf[i]   <= 1'b0;
                end else if (hit[i]) begin
                    if (&count[i]) begin
                        ovf[i] <= 1'b1;
                        if (SATURATE == 0) begin
                            count[i] <= '0;
                        end
                    end else begin
                        count[i] <= count[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef PERF_COUNTER_SNAPSHOT_EN
    logic [WIDTH-1:0] shadow [CHANNELS];

    // Shadow capture of every live count (pre-update) on snap; a same-cycle clear still yields the pre-clear value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else if (bus.snap) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= count[i];
            end
        end
    end

    // Readout source is the frozen shadow copy.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            src[i] = shadow[i];
        end
    end
`else
    logic unused_snap;
    assign unused_snap = bus.snap;

    // Readout source is the live count.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            src[i] = count[i];
        end
    end
`endif

    // Channel select; an index beyond the last channel matches nothing and reads as zero.
    always_comb begin
        sel_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                sel_val = src[i];
            end
        end
    end

    // Registered readout of the value selected during the cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= sel_val;
        end
    end

    assign bus.overflow = ovf;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: three bank configurations driven in parallel and compared every cycle with a run-length model.
// Latency: outputs sampled 1ns after each rising edge; model advances on the same edge from pre-edge inputs.
// Backpressure: none; fixed cycle counts only, so the run always terminates.
`timescale 1ns/1ps
module tb_perf_counter_bank;
    logic clk;
    logic rst;
    logic en;
    logic [3:0] ev;
    logic [3:0] cl;
    logic sn;
    logic [1:0] sel;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Configuration table: cfg0 is the default bank, cfg1 a small wrapping bank, cfg2 a small saturating bank.
    int cw [3] = '{16, 4, 4};
    int cn [3] = '{4, 4, 3};
    int cq [3] = '{3, 2, 1};
    int cs [3] = '{0, 0, 1};

    perf_counter_bank_if #(.WIDTH(16), .CHANNELS(4)) bus0 ();
    perf_counter_bank_if #(.WIDTH(4),  .CHANNELS(4)) bus1 ();
    perf_counter_bank_if #(.WIDTH(4),  .CHANNELS(3)) bus2 ();

    perf_counter_bank #(.WIDTH(16), .CHANNELS(4), .QUAL(3), .SATURATE(0)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
    perf_counter_bank #(.WIDTH(4),  .CHANNELS(4), .QUAL(2), .SATURATE(0)) dut1 (.clk(clk), .reset(rst), .bus(bus1));
    perf_counter_bank #(.WIDTH(4),  .CHANNELS(3), .QUAL(1), .SATURATE(1)) dut2 (.clk(clk), .reset(rst), .bus(bus2));

    assign bus0.enable = en;  assign bus0.evt = ev;      assign bus0.clear = cl;      assign bus0.snap = sn;  assign bus0.rd_sel = sel;
    assign bus1.enable = en;  assign bus1.evt = ev;      assign bus1.clear = cl;      assign bus1.snap = sn;  assign bus1.rd_sel = sel;
    assign bus2.enable = en;  assign bus2.evt = ev[2:0]; assign bus2.clear = cl[2:0]; assign bus2.snap = sn;  assign bus2.rd_sel = sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per channel, count, length of the current high run, sticky flag, shadow, readout.
    int unsigned m_cnt [3][4];
    int unsigned m_shd [3][4];
    int          m_run [3][4];
    bit          m_ov  [3][4];
    int unsigned m_rd  [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_rd[k] = 0;
            for (int c = 0; c < 4; c++) begin
                m_cnt[k][c] = 0; m_shd[k][c] = 0; m_run[k][c] = 0; m_ov[k][c] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int unsigned maxv;
            maxv = (32'd1 << cw[k]) - 1;
`ifdef PERF_COUNTER_SNAPSHOT_EN
            m_rd[k] = (int'(sel) < cn[k]) ? m_shd[k][sel] : 0;
            if (sn) for (int c = 0; c < cn[k]; c++) m_shd[k][c] = m_cnt[k][c];
`else
            m_rd[k] = (int'(sel) < cn[k]) ? m_cnt[k][sel] : 0;
`endif
            for (int c = 0; c < cn[k]; c++) begin
                if (cl[c]) begin
                    m_cnt[k][c] = 0; m_ov[k][c] = 1'b0; m_run[k][c] = 0;
                end else if (!(en && ev[c])) begin
                    m_run[k][c] = 0;
                end else begin
                    m_run[k][c]++;
                    if (m_run[k][c] == cq[k]) begin
                        if (m_cnt[k][c] == maxv) begin
                            m_ov[k][c] = 1'b1;
                            m_cnt[k][c] = (cs[k] != 0) ? maxv : 0;
                        end else begin
                            m_cnt[k][c]++;
                        end
                    end
                end
            end
        end
    endtask

    function automatic int unsigned get_rd(int k);
        case (k)
            0:       return int'(bus0.rd_data);
            1:       return int'(bus1.rd_data);
            default: return int'(bus2.rd_data);
        endcase
    endfunction

    function automatic int unsigned get_ov(int k);
        case (k)
            0:       return int'(bus0.overflow);
            1:       return int'(bus1.overflow);
            default: return int'(bus2.overflow);
        endcase
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            int unsigned eov;
            eov = 0;
            for (int c = 0; c < cn[k]; c++) if (m_ov[k][c]) eov |= (32'd1 << c);
            check($sformatf("cfg%0d rd_data", k), get_rd(k), m_rd[k]);
            check($sformatf("cfg%0d overflow", k), get_ov(k), eov);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) model_reset(); else model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic       en;
        logic [3:0] ev;
        logic [3:0] cl;
        logic [1:0] sel;
        int unsigned exp_rd;
    } vec_t;

    function automatic vec_t mk(logic e, logic [3:0] v, logic [3:0] c, logic [1:0] s, int unsigned r);
        vec_t t;
        t.en = e; t.ev = v; t.cl = c; t.sel = s; t.exp_rd = r;
        return t;
    endfunction

    vec_t tbl [$];

    initial begin
        // Directed vectors for cfg0 (QUAL=3): long run on ch0, clear mid-run on ch3, enable masking on ch2.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, 4'b0001, 4'b0000, 2'd0, 0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1'b1, 4'b0001, 4'b0000, 2'd0, 1));
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1));
        tbl.push_back(mk(1'b1, 4'b1000, 4'b0000, 2'd3, 0));
        tbl.push_back(mk(1'b1, 4'b1000, 4'b0000, 2'd3, 0));
        tbl.push_back(mk(1'b1, 4'b1000, 4'b1000, 2'd3, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, 4'b1000, 4'b0000, 2'd3, 0));
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd3, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 4'b0100, 4'b0000, 2'd2, 0));
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd2, 0));
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1));

        rst = 1'b1; en = 1'b0; ev = '0; cl = '0; sn = 1'b0; sel = '0;
        model_reset();
        tick(); tick();
        rst = 1'b0;

        foreach (tbl[i]) begin
            en = tbl[i].en; ev = tbl[i].ev; cl = tbl[i].cl; sel = tbl[i].sel;
            tick();
            check($sformatf("vector %0d cfg0 rd_data", i), get_rd(0), tbl[i].exp_rd);
        end

        // Runs of two on ch1 never reach QUAL=3; runs of three count once each.
        en = 1'b1; cl = '0; sel = 2'd1;
        for (int p = 0; p < 5; p++) begin
            ev = 4'b0010; tick(); tick();
            ev = 4'b0000; tick();
        end
        check("short runs cfg0 count1", get_rd(0), 0);
        for (int p = 0; p < 5; p++) begin
            ev = 4'b0010; tick(); tick(); tick();
            ev = 4'b0000; tick();
        end
        check("full runs cfg0 count1", get_rd(0), 5);

        // Asynchronous reset between edges after two high cycles; post-reset short run does not count.
        sel = 2'd0; ev = 4'b0000; tick();
        ev = 4'b0001; tick(); tick();
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("async reset cfg0 rd_data", get_rd(0), 0);
        check("async reset cfg1 rd_data", get_rd(1), 0);
        check("async reset cfg0 overflow", get_ov(0), 0);
        tick();
        rst = 1'b0;
        tick(); tick();
        ev = 4'b0000; tick(); tick();
        check("post-reset short run cfg0", get_rd(0), 0);

        // Sixteen qualified runs on ch2 of the 4-bit banks: wrap in cfg1, saturate in cfg2, both flag overflow.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        sel = 2'd2;
        for (int p = 0; p < 16; p++) begin
            ev = 4'b0100; tick(); tick();
            ev = 4'b0000; tick();
        end
        check("wrap cfg1 count2", get_rd(1), 0);
        check("wrap cfg1 overflow", get_ov(1), 4'b0100);
        check("saturate cfg2 count2", get_rd(2), 15);
        check("saturate cfg2 overflow", get_ov(2), 3'b100);
        sel = 2'd3; tick();
        check("out-of-range select cfg2", get_rd(2), 0);
        sel = 2'd2; cl = 4'b0100; tick();
        cl = 4'b0000; tick();
        check("clear cfg1 count2", get_rd(1), 0);
        check("clear cfg1 overflow", get_ov(1), 0);
        check("clear cfg2 count2", get_rd(2), 0);
        check("clear cfg2 overflow", get_ov(2), 0);

`ifdef PERF_COUNTER_SNAPSHOT_EN
        // Snapshot on the qualifying edge captures the pre-update count.
        sel = 2'd0;
        for (int p = 0; p < 7; p++) begin
            ev = 4'b0001; tick(); tick(); tick();
            ev = 4'b0000; tick();
        end
        ev = 4'b0001; tick(); tick();
        sn = 1'b1; tick();
        sn = 1'b0; ev = 4'b0000; tick();
        check("snapshot before increment", get_rd(0), 7);
        sn = 1'b1; tick();
        sn = 1'b0; tick();
        check("snapshot after increment", get_rd(0), 8);
`endif

        // Randomized traffic: toggling levels give runs of varied length on all channels at once.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++) if ($urandom_range(3) == 0) ev[c] = ~ev[c];
            for (int c = 0; c < 4; c++) cl[c] = ($urandom_range(39) == 0);
            en  = ($urandom_range(15) != 0);
            sn  = ($urandom_range(1) == 1);
            sel = 2'($urandom_range(3));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
